mem_core_dp: RTL and testbench



---
 rtl/mem_core_dp.sv | 148 ++++++++++++++
 tb/tb_mem_core_dp.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_core_dp.sv
// Simple dual-port RAM with byte strobes, 1- or 2-stage registered read path
// and a built-in sequencer that zeroes every word after reset or on request.
module mem_core_dp #(
  parameter int unsigned ElemWidth   = 32,
  parameter int unsigned AddrWidth   = 8,
  parameter int unsigned ReadLatency = 1,
  parameter bit          WriteFirst  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   clear_i,
  output logic                   busy_o,
  input  logic                   we_i,
  input  logic [AddrWidth-1:0]   waddr_i,
  input  logic [ElemWidth-1:0]   wdata_i,
  input  logic [ElemWidth/8-1:0] wstrb_i,
  input  logic                   re_i,
  input  logic [AddrWidth-1:0]   raddr_i,
  output logic [ElemWidth-1:0]   rdata_o,
  output logic                   rvalid_o
);

  localparam int unsigned StrbWidth = ElemWidth / 8;
  localparam int unsigned Depth     = 2 ** AddrWidth;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t                 r_state;
  logic [AddrWidth-1:0]   r_ptr;
  logic                   r_busy;
  logic [ElemWidth-1:0]   r_mem [Depth];

  logic                   w_idle;
  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic                   w_collide;
  logic [ElemWidth-1:0]   w_old;
  logic [ElemWidth-1:0]   w_merged;
  logic [ElemWidth-1:0]   w_rd_word;

  logic                   r_v1;
  logic [ElemWidth-1:0]   r_d1;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_wr_acc = we_i & w_idle;
  assign w_rd_acc = re_i & w_idle;
  assign busy_o   = r_busy;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_ptr <= r_ptr + AddrWidth'(1);
          if (r_ptr == '1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clear_i) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset so it can map onto block RAM; the sequencer zeroes it.
  always_ff @(posedge clk_i) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_acc) begin
      for (int unsigned k = 0; k < StrbWidth; k++) begin
        if (wstrb_i[k]) r_mem[waddr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
      end
    end
  end

  assign w_old     = r_mem[raddr_i];
  assign w_collide = w_wr_acc && (waddr_i == raddr_i);

  always_comb begin
    w_merged = w_old;
    for (int unsigned k = 0; k < StrbWidth; k++) begin
      if (wstrb_i[k]) w_merged[k*8 +: 8] = wdata_i[k*8 +: 8];
    end
  end

  assign w_rd_word = (WriteFirst && w_collide) ? w_merged : w_old;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_rd_acc;
      if (w_rd_acc) r_d1 <= w_rd_word;
    end
  end

  // Each stage loads only on a valid beat, so rdata_o holds between reads.
  if (ReadLatency == 1) begin : g_lat1
    assign rdata_o  = r_d1;
    assign rvalid_o = r_v1;
  end else begin : g_lat2
    logic                 r_v2;
    logic [ElemWidth-1:0] r_d2;

    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
        r_v2 <= 1'b0;
        r_d2 <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_d2 <= r_d1;
      end
    end

    assign rdata_o  = r_d2;
    assign rvalid_o = r_v2;
  end

`ifdef SIMULATION
  function automatic void backdoor_write(input logic [AddrWidth-1:0] addr,
                                         input logic [ElemWidth-1:0] data);
    r_mem[addr] = data;
  endfunction

  function automatic logic [ElemWidth-1:0] backdoor_read(input logic [AddrWidth-1:0] addr);
    return r_mem[addr];
  endfunction
`endif

endmodule

// File: tb/tb_mem_core_dp.sv
// Randomized bench for mem_core_dp: two instances (latency 1 / write-first and
// latency 2 / read-first) compared every cycle against a word-level reference model.
module tb_mem_core_dp;

  localparam int AW    = 4;
  localparam int EW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          clear = 1'b0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] raddr = '0;
  logic [EW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;

  logic          busy_a, rvalid_a, busy_b, rvalid_b;
  logic [EW-1:0] rdata_a, rdata_b;

  always #5 clk = ~clk;

  mem_core_dp #(.ElemWidth(EW), .AddrWidth(AW), .ReadLatency(1), .WriteFirst(1'b1)) u_dut_a (
    .clk_i(clk), .arst_i(arst), .clear_i(clear), .busy_o(busy_a),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wstrb_i(wstrb),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_a), .rvalid_o(rvalid_a)
  );

  mem_core_dp #(.ElemWidth(EW), .AddrWidth(AW), .ReadLatency(2), .WriteFirst(1'b0)) u_dut_b (
    .clk_i(clk), .arst_i(arst), .clear_i(clear), .busy_o(busy_b),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wstrb_i(wstrb),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_b), .rvalid_o(rvalid_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [EW-1:0] data;
  } rd_t;

  rd_t           q_a[$];
  rd_t           q_b[$];
  logic [EW-1:0] m [DEPTH];
  int            busy_left;
  int            cyc = 0;
  logic          exp_va, exp_vb;
  logic [EW-1:0] exp_da, exp_db;
  logic [EW-1:0] old_w, new_w;

  function automatic logic [EW-1:0] merge(input logic [EW-1:0] o, input logic [EW-1:0] d,
                                          input logic [3:0] s);
    logic [EW-1:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (s[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      busy_left = DEPTH;
      q_a.delete();
      q_b.delete();
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
      exp_va = 1'b0; exp_vb = 1'b0;
      exp_da = '0;   exp_db = '0;
    end else begin
      cyc++;
      if (busy_left > 0) begin
        busy_left--;
      end else begin
        if (re) begin
          old_w = m[raddr];
          new_w = merge(old_w, wdata, wstrb);
          q_a.push_back('{due: cyc, data: (we && waddr == raddr) ? new_w : old_w});
          q_b.push_back('{due: cyc + 1, data: old_w});
        end
        if (we) m[waddr] = merge(m[waddr], wdata, wstrb);
        if (clear) begin
          busy_left = DEPTH;
          for (int i = 0; i < DEPTH; i++) m[i] = '0;
        end
      end
      exp_va = 1'b0;
      if (q_a.size() > 0 && q_a[0].due == cyc) begin
        exp_va = 1'b1; exp_da = q_a[0].data; q_a.delete(0);
      end
      exp_vb = 1'b0;
      if (q_b.size() > 0 && q_b[0].due == cyc) begin
        exp_vb = 1'b1; exp_db = q_b[0].data; q_b.delete(0);
      end
    end
  end

  always @(negedge clk) begin
    check_val("busy_a",   busy_a,   (busy_left > 0) ? 1 : 0);
    check_val("busy_b",   busy_b,   (busy_left > 0) ? 1 : 0);
    check_val("rvalid_a", rvalid_a, exp_va);
    check_val("rvalid_b", rvalid_b, exp_vb);
    check_val("rdata_a",  rdata_a,  exp_da);
    check_val("rdata_b",  rdata_b,  exp_db);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [EW-1:0] wd,
                       input logic [3:0] ws, input logic r, input logic [AW-1:0] ra,
                       input logic c);
    we = w; waddr = wa; wdata = wd; wstrb = ws; re = r; raddr = ra; clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) drive(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
  endtask

  task automatic rand_cycle(input int clr_odds);
    drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom,
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          AW'($urandom_range(0, DEPTH - 1)), (clr_odds > 0) && ($urandom_range(0, clr_odds) == 0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    idle(DEPTH + 2);
    read_all();
    idle(3);

    drive(1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 1'b0, '0, 1'b0);
    drive(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, '0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
    drive(1'b1, 4'd7, 32'hFFFFFFFF, 4'h0, 1'b1, 4'd7, 1'b0);
    idle(3);

    drive(1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 1'b1, 4'd5, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
    idle(3);

    for (int a = 0; a < 4; a++) drive(1'b1, AW'(a), 32'(10 + a), 4'hF, 1'b0, '0, 1'b0);
    for (int a = 0; a < 4; a++) drive(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
    idle(4);

    for (int i = 0; i < 400; i++) rand_cycle(63);
    idle(DEPTH + 2);

    for (int a = 0; a < DEPTH; a++) drive(1'b1, AW'(a), $urandom, 4'hF, 1'b0, '0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) rand_cycle(0);
    idle(2);
    read_all();
    idle(3);

    drive(1'b1, 4'd9, 32'hCAFEF00D, 4'hF, 1'b0, '0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b0);
    idle(3);
    drive(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b1);
    idle(6);
    #2 arst = 1'b1;
    #1;
    check_val("async_busy_a",   busy_a,   1);
    check_val("async_busy_b",   busy_b,   1);
    check_val("async_rvalid_a", rvalid_a, 0);
    check_val("async_rvalid_b", rvalid_b, 0);
    check_val("async_rdata_a",  rdata_a,  0);
    check_val("async_rdata_b",  rdata_b,  0);
    @(posedge clk);
    #1 arst = 1'b0;
    idle(DEPTH + 2);
    read_all();
    for (int i = 0; i < 60; i++) rand_cycle(0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
